// File: rtl/cdb_scheduler_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// cdb_scheduler_pkg : CDB tag constants, widths and requester indices
// Revision: 1.0
// ------------------------------------------------------------------
package cdb_scheduler_pkg;

  localparam int CDB_DATA_W = 16;
  localparam int CDB_TAG_W  = 3;
  localparam int NUM_REQ    = 4;

  localparam logic [CDB_TAG_W-1:0] FREE_REGISTER     = 3'd0;
  localparam logic [CDB_TAG_W-1:0] RES_STATION_ADD1  = 3'd1;
  localparam logic [CDB_TAG_W-1:0] RES_STATION_ADD2  = 3'd2;
  localparam logic [CDB_TAG_W-1:0] RES_STATION_LOAD1 = 3'd3;
  localparam logic [CDB_TAG_W-1:0] RES_STATION_LOAD2 = 3'd4;

  localparam logic [1:0] REQ_ADD1  = 2'd0;
  localparam logic [1:0] REQ_ADD2  = 2'd1;
  localparam logic [1:0] REQ_LOAD1 = 2'd2;
  localparam logic [1:0] REQ_LOAD2 = 2'd3;

  function automatic logic [CDB_TAG_W-1:0] tag_of(input logic [1:0] idx);
    logic [CDB_TAG_W-1:0] t;
    t = FREE_REGISTER;
    case (idx)
      REQ_ADD1:  t = RES_STATION_ADD1;
      REQ_ADD2:  t = RES_STATION_ADD2;
      REQ_LOAD1: t = RES_STATION_LOAD1;
      REQ_LOAD2: t = RES_STATION_LOAD2;
      default:   t = FREE_REGISTER;
    endcase
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_scheduler_rr_arbiter4.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_arbiter4 : combinational 4-way round-robin pick starting at ptr
// Revision: 1.0
// ------------------------------------------------------------------
module rr_arbiter4
  import cdb_scheduler_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] winner,
  output logic       any
);

  always_comb begin
    logic [1:0] idx;
    idx    = '0;
    gnt    = '0;
    winner = '0;
    any    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + 2'(k);  // 2-bit add wraps 3 -> 0
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        winner   = idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdb_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------
// cdb_scheduler : round-robin Common Data Bus arbiter with registered
//                 broadcast and a sticky starvation monitor
// Revision: 1.0
// ------------------------------------------------------------------
module cdb_scheduler
  import cdb_scheduler_pkg::*;
#(
  parameter int DATA_W   = CDB_DATA_W,
  parameter int TAG_W    = CDB_TAG_W,
  parameter int MAX_WAIT = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Flush,
  input  logic [3:0]        Req,
  input  logic [DATA_W-1:0] Data_ADD1,
  input  logic [DATA_W-1:0] Data_ADD2,
  input  logic [DATA_W-1:0] Data_LOAD1,
  input  logic [DATA_W-1:0] Data_LOAD2,
  output logic [3:0]        Grant,
  output logic              CDB_Valid,
  output logic [TAG_W-1:0]  Qi_CDB,
  output logic [DATA_W-1:0] Qi_CDB_data,
  output logic              Starve_Err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [1:0]        rr_ptr;
  logic [3:0]        eligible;
  logic [3:0]        arb_gnt;
  logic [1:0]        arb_winner;
  logic              arb_any;
  logic [DATA_W-1:0] win_data;
  logic [CNT_W-1:0]  wait_cnt [NUM_REQ];
  logic [CNT_W-1:0]  wait_nxt [NUM_REQ];
  logic              starve_hit;

  // The unit granted this cycle still holds Req until it sees Grant.
  assign eligible = Req & ~Grant;

  rr_arbiter4 u_arb (
    .req    (eligible),
    .ptr    (rr_ptr),
    .gnt    (arb_gnt),
    .winner (arb_winner),
    .any    (arb_any)
  );

  always_comb begin
    win_data = Data_ADD1;
    case (arb_winner)
      REQ_ADD1:  win_data = Data_ADD1;
      REQ_ADD2:  win_data = Data_ADD2;
      REQ_LOAD1: win_data = Data_LOAD1;
      REQ_LOAD2: win_data = Data_LOAD2;
      default:   win_data = Data_ADD1;
    endcase
  end

  always_comb begin
    starve_hit = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wait_nxt[i] = wait_cnt[i];
      if (!Req[i] || Grant[i] || arb_gnt[i])
        wait_nxt[i] = '0;
      else if (wait_cnt[i] != CNT_W'(MAX_WAIT))
        wait_nxt[i] = wait_cnt[i] + 1'b1;
      if (wait_nxt[i] == CNT_W'(MAX_WAIT))
        starve_hit = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      Grant       <= '0;
      CDB_Valid   <= 1'b0;
      Qi_CDB      <= '0;
      Qi_CDB_data <= '0;
      Starve_Err  <= 1'b0;
      rr_ptr      <= '0;
      for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
    end else if (Flush) begin
      Grant     <= '0;
      CDB_Valid <= 1'b0;
      Qi_CDB    <= '0;
      for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
    end else begin
      Grant     <= arb_gnt;
      CDB_Valid <= arb_any;
      if (arb_any) begin
        Qi_CDB      <= TAG_W'(tag_of(arb_winner));
        Qi_CDB_data <= win_data;
        rr_ptr      <= arb_winner + 2'd1;
      end else begin
        Qi_CDB <= TAG_W'(FREE_REGISTER);
      end
      for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= wait_nxt[i];
      if (starve_hit) Starve_Err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdb_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_cdb_scheduler : directed vectors for cdb_scheduler
// Revision: 1.0
// ------------------------------------------------------------------
module tb_cdb_scheduler;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Flush = 1'b0;
  logic [3:0]  Req = '0;
  logic [15:0] Data_ADD1 = '0, Data_ADD2 = '0, Data_LOAD1 = '0, Data_LOAD2 = '0;
  logic [3:0]  Grant;
  logic        CDB_Valid;
  logic [2:0]  Qi_CDB;
  logic [15:0] Qi_CDB_data;
  logic        Starve_Err;

  int total = 0;
  int bad   = 0;

  cdb_scheduler dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Flush       (Flush),
    .Req         (Req),
    .Data_ADD1   (Data_ADD1),
    .Data_ADD2   (Data_ADD2),
    .Data_LOAD1  (Data_LOAD1),
    .Data_LOAD2  (Data_LOAD2),
    .Grant       (Grant),
    .CDB_Valid   (CDB_Valid),
    .Qi_CDB      (Qi_CDB),
    .Qi_CDB_data (Qi_CDB_data),
    .Starve_Err  (Starve_Err)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_bcast(input string tag, input logic [3:0] g, input logic v,
                           input logic [2:0] q);
    chk({tag, ".grant"}, 32'(Grant), 32'(g));
    chk({tag, ".valid"}, 32'(CDB_Valid), 32'(v));
    chk({tag, ".tag"}, 32'(Qi_CDB), 32'(q));
  endtask

  initial begin
    logic [3:0] exp_g;
    logic [2:0] exp_t;
    logic [3:0] req_seq [4];
    req_seq[0] = 4'b1111; req_seq[1] = 4'b1110;
    req_seq[2] = 4'b1100; req_seq[3] = 4'b1000;

    // reset then idle
    Reset = 1'b0;
    tick(); tick();
    chk_bcast("reset", 4'b0000, 1'b0, 3'd0);
    chk("reset.data", 32'(Qi_CDB_data), 32'h0);
    chk("reset.err", 32'(Starve_Err), 32'h0);
    Reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle.valid", 32'(CDB_Valid), 32'h0);
    end

    // single request
    Req = 4'b0001; Data_ADD1 = 16'h00A5;
    tick();
    chk_bcast("single", 4'b0001, 1'b1, 3'd1);
    chk("single.data", 32'(Qi_CDB_data), 32'h00A5);
    Req = 4'b0000;
    tick();
    chk("single.after", 32'(CDB_Valid), 32'h0);

    // full contention from a fresh pointer
    Reset = 1'b0; tick(); Reset = 1'b1;
    Data_ADD1 = 16'd1; Data_ADD2 = 16'd2; Data_LOAD1 = 16'd3; Data_LOAD2 = 16'd4;
    for (int i = 0; i < 4; i++) begin
      Req = req_seq[i];
      tick();
      exp_g = 4'b0001 << i;
      exp_t = 3'(i + 1);
      chk_bcast("contend", exp_g, 1'b1, exp_t);
      chk("contend.data", 32'(Qi_CDB_data), 32'(i + 1));
    end
    Req = 4'b0000;
    tick();
    chk("contend.end", 32'(CDB_Valid), 32'h0);
    chk("contend.err", 32'(Starve_Err), 32'h0);

    // persistent ADD1 + LOAD2 alternate
    Req = 4'b1001;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_g = (i % 2 == 0) ? 4'b0001 : 4'b1000;
      exp_t = (i % 2 == 0) ? 3'd1 : 3'd4;
      chk_bcast("fair", exp_g, 1'b1, exp_t);
    end
    Req = 4'b0000;
    tick();
    chk("fair.err", 32'(Starve_Err), 32'h0);

    // flush suppresses the grant for one edge
    Req = 4'b0100; Flush = 1'b1;
    tick();
    chk_bcast("flush", 4'b0000, 1'b0, 3'd0);
    Flush = 1'b0;
    tick();
    chk_bcast("flush.after", 4'b0100, 1'b1, 3'd3);
    chk("flush.data", 32'(Qi_CDB_data), 32'd3);
    Req = 4'b0000;
    tick();

    // reset mid-broadcast; pointer restarts at ADD1
    Req = 4'b1111;
    tick();
    chk_bcast("midrst.pre", 4'b1000, 1'b1, 3'd4);
    Reset = 1'b0;
    tick();
    chk_bcast("midrst", 4'b0000, 1'b0, 3'd0);
    chk("midrst.data", 32'(Qi_CDB_data), 32'h0);
    Reset = 1'b1;
    tick();
    chk_bcast("midrst.first", 4'b0001, 1'b1, 3'd1);
    Req = 4'b0000;
    tick();
    chk("final.err", 32'(Starve_Err), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cdb_scheduler.md
Name: cdb_scheduler

Overview:
- Clocked, fair arbiter for the single Common Data Bus (CDB) shared by the four reservation-station functional units: ADD1, ADD2, LOAD1 and LOAD2.
- Each unit raises a level request with its result and holds it. The scheduler grants one unit per cycle in round-robin order.
- The winner's tag and data are broadcast as registered outputs.
- The block replaces level/latch-based CDB selection. It feeds the register-status table and all reservation stations that snoop Qi_CDB.

Parameters:
- DATA_W, 16, width of result data and CDB data.
- TAG_W, 3, width of the reservation-station tag.
- MAX_WAIT, 8, cycles a held request may wait before Starve_Err is flagged.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-low reset.
- Flush  in  1  synchronous; cancels the current broadcast (e.g. on mispredict/restart).
- Req  in  4  level request per unit; bit0=ADD1, bit1=ADD2, bit2=LOAD1, bit3=LOAD2.
- Data_ADD1, Data_ADD2, Data_LOAD1, Data_LOAD2  in  DATA_W each  result data; stable while the matching Req bit is high.
- Grant  out  4  one-hot registered grant, one cycle wide.
- CDB_Valid  out  1  registered; Qi_CDB/Qi_CDB_data are meaningful.
- Qi_CDB  out  TAG_W  broadcast tag.
- Qi_CDB_data  out  DATA_W  broadcast data.
- Starve_Err  out  1  sticky error flag.

Behaviour:
- Tag constants: FREE_REGISTER=0, RES_STATION_ADD1=1, RES_STATION_ADD2=2, RES_STATION_LOAD1=3, RES_STATION_LOAD2=4. Requester index i maps to tag i+1.
- Reset (Reset==0 at a rising edge): Grant=0, CDB_Valid=0, Qi_CDB=0, Qi_CDB_data=0, Starve_Err=0, rr pointer=0, all wait counters=0. Reset overrides Flush and Req.
- Eligible set each edge: Req & ~Grant. The unit granted in the current cycle is masked because its Req is still high until it observes Grant.
- Selection: scan the eligible set starting at the rr pointer, wrapping 3->0. The first set bit wins.
- On a win at edge N:
  - Grant = onehot(winner), CDB_Valid=1, Qi_CDB=winner+1, Qi_CDB_data=Data_winner. All are visible from edge N until edge N+1.
  - rr pointer = (winner+1) mod 4.
- Latency: Req high before edge N gives the broadcast in the cycle after edge N (1 cycle) when no contention.
- Requester contract:
  - Drop Req at the edge after seeing Grant, or keep it high only if a new result is ready.
  - A new result may be presented back-to-back. Because of the mask it is served no earlier than 2 cycles later.
- No eligible request: Grant=0, CDB_Valid=0, Qi_CDB=0. Qi_CDB_data holds its last value (don't-care). Pointer is unchanged.
- Flush=1 at an edge: Grant=0, CDB_Valid=0, Qi_CDB=0, wait counters cleared. Pointer and Starve_Err unchanged; no grant is issued that edge.
- Simultaneous requests: exactly one grant per cycle. The other requests keep waiting. Grant is never more than one-hot.
- Starvation monitor:
  - A per-unit wait counter increments while Req[i] & ~Grant[i], saturating at MAX_WAIT. It clears when Grant[i] is issued or Req[i] is low.
  - Reaching MAX_WAIT sets Starve_Err, which stays set until Reset. With 4 units round-robin, the worst-case wait is 4 cycles, so Starve_Err must never assert in legal operation.
- Reset asserted mid-broadcast: outputs clear at that edge. Requesters must re-present.

Decomposition:
- Shared package/include: tag constants (FREE_REGISTER, RES_STATION_*), TAG_W, DATA_W, requester index constants.
- One natural sub-module: rr_arbiter4. It is combinational: given req[3:0] and ptr[1:0], it returns one-hot gnt and winner index.
- Registers, the data mux, Flush handling and wait counters stay in cdb_scheduler.

Test Plan:
- Reset then idle: hold Reset=0 two cycles, Req=0 -> all outputs 0, CDB_Valid stays 0 for 10 cycles.
- Single request: Req=0001, Data_ADD1=16'h00A5 for one cycle -> the next cycle has Grant=0001, Qi_CDB=1, Qi_CDB_data=16'h00A5, CDB_Valid=1, then CDB_Valid=0.
- Full contention: Req=1111 held, each unit dropping its bit after its grant, data 1/2/3/4 -> tags broadcast 1,2,3,4 on consecutive cycles, each exactly once, Starve_Err=0.
- Fairness with persistent requesters: LOAD2 and ADD1 re-request continuously (Req=1001) -> grants alternate 0001,1000,0001..., and neither waits more than 2 cycles.
- Flush: Req=0100 with Flush=1 at the same edge -> no grant that cycle. Next edge Flush=0 -> Grant=0100, Qi_CDB=3.
- Reset mid-operation: Req=1111, Reset=0 while CDB_Valid=1 -> the next cycle has all outputs 0. After release the pointer restarts at ADD1 (first tag 1).
